// File: rtl/button_debounce.sv
// Push-button conditioner: per-channel 2-flop synchroniser, stability-counter
// debouncer, registered press/release pulses and a clearable wrapping press counter.
module button_debounce #(
  parameter int NUM_BUTTONS     = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNT_W         = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BUTTONS-1:0]         btn_raw_i,
  input  logic [NUM_BUTTONS-1:0]         count_clr_i,
  output logic [NUM_BUTTONS-1:0]         btn_o,
  output logic [NUM_BUTTONS-1:0]         press_o,
  output logic [NUM_BUTTONS-1:0]         release_o,
  output logic [NUM_BUTTONS*COUNT_W-1:0] press_count_o
);

  localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar i;
  generate
    for (i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      logic               s1;
      logic               s2;
      logic               stable;
      logic [CNT_W-1:0]   stab_cnt;
      logic               press_q;
      logic               release_q;
      logic [COUNT_W-1:0] count_q;
      logic               accept;
      logic               accept_press;

      // The new level is taken on the edge where the counter already shows
      // DEBOUNCE_CYCLES-1 disagreeing samples, so this edge is the last one.
      assign accept       = (s2 != stable) && (stab_cnt == LAST);
      assign accept_press = accept && s2;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1        <= 1'b0;
          s2        <= 1'b0;
          stable    <= 1'b0;
          stab_cnt  <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          count_q   <= '0;
        end else begin
          s1        <= btn_raw_i[i];
          s2        <= s1;
          press_q   <= accept_press;
          release_q <= accept && !s2;

          if (s2 == stable) begin
            stab_cnt <= '0;
          end else if (accept) begin
            stable   <= s2;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + CNT_W'(1);
          end

          // A clear colliding with an accepted press keeps that press.
          if (count_clr_i[i]) begin
            count_q <= accept_press ? COUNT_W'(1) : '0;
          end else if (accept_press) begin
            count_q <= count_q + COUNT_W'(1);
          end
        end
      end

      assign btn_o[i]                             = stable;
      assign press_o[i]                           = press_q;
      assign release_o[i]                         = release_q;
      assign press_count_o[i*COUNT_W +: COUNT_W]  = count_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (2 buttons, 4-cycle debounce, 4-bit counters):
// stimulus queues expected pulse events, a negedge monitor pops and compares them.
module tb_button_debounce;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int CW = 4;
  localparam int LAT = 2 + DC;

  logic            clk;
  logic            reset;
  logic [NB-1:0]   btn_raw_i;
  logic [NB-1:0]   count_clr_i;
  logic [NB-1:0]   btn_o;
  logic [NB-1:0]   press_o;
  logic [NB-1:0]   release_o;
  logic [NB*CW-1:0] press_count_o;

  button_debounce #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC),
    .COUNT_W        (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw_i    (btn_raw_i),
    .count_clr_i  (count_clr_i),
    .btn_o        (btn_o),
    .press_o      (press_o),
    .release_o    (release_o),
    .press_count_o(press_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] btn;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  // Every pulse the DUT shows must match the oldest queued expectation.
  always @(negedge clk) begin
    if ((press_o | release_o) != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_pulse cyc=%0d press=%b rel=%b btn=%b cnt=%h (no event expected)",
                 cyc, press_o, release_o, btn_o, press_count_o);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.at == cyc && e.press == press_o && e.rel == release_o &&
            e.btn == btn_o && e.cnt == press_count_o) begin
          passed++;
        end else begin
          $display("[TB] FAIL pulse_event got cyc=%0d press=%b rel=%b btn=%b cnt=%h want cyc=%0d press=%b rel=%b btn=%b cnt=%h",
                   cyc, press_o, release_o, btn_o, press_count_o,
                   e.at, e.press, e.rel, e.btn, e.cnt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] raw, input logic [1:0] clr);
    btn_raw_i   = raw;
    count_clr_i = clr;
  endtask

  task automatic expectEvent(input int at, input logic [1:0] press, input logic [1:0] rel,
                             input logic [1:0] btn, input logic [7:0] cnt);
    ev_t e;
    e.at = at; e.press = press; e.rel = rel; e.btn = btn; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] btn, input logic [1:0] press,
                             input logic [1:0] rel, input logic [7:0] cnt);
    checks++;
    if (btn_o == btn && press_o == press && release_o == rel && press_count_o == cnt) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s cyc=%0d got btn=%b press=%b rel=%b cnt=%h want btn=%b press=%b rel=%b cnt=%h",
               name, cyc, btn_o, press_o, release_o, press_count_o, btn, press, rel, cnt);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00);
    tick(3);
    reset = 1'b0;
  endtask

  // Clean press then release of one channel, queuing both events.
  task automatic pressRelease(input logic [1:0] mask, input logic [7:0] cnt_after);
    int t;
    t = cyc;
    applyStimulus(mask, 2'b00);
    expectEvent(t + LAT, mask, 2'b00, mask, cnt_after);
    tick(LAT + 1);
    t = cyc;
    applyStimulus(2'b00, 2'b00);
    expectEvent(t + LAT, 2'b00, mask, 2'b00, cnt_after);
    tick(LAT + 1);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    applyStimulus(2'b11, 2'b00);
    tick(3);
    checkOutput("reset_state_raw_high", 2'b00, 2'b00, 2'b00, 8'h00);
    applyReset();

    // Clean press on button 0
    t = cyc;
    applyStimulus(2'b01, 2'b00);
    expectEvent(t + 6, 2'b01, 2'b00, 2'b01, 8'h01);
    tick(5);
    checkOutput("before_accept", 2'b00, 2'b00, 2'b00, 8'h00);
    tick(2);
    checkOutput("after_press_pulse", 2'b01, 2'b00, 2'b00, 8'h01);
    tick(3);
    t = cyc;
    applyStimulus(2'b00, 2'b00);
    expectEvent(t + 6, 2'b00, 2'b01, 2'b00, 8'h01);
    tick(8);
    checkOutput("after_release", 2'b00, 2'b00, 2'b00, 8'h01);

    // Glitches
    applyReset();
    applyStimulus(2'b01, 2'b00);
    tick(3);
    applyStimulus(2'b00, 2'b00);
    tick(10);
    checkOutput("glitch_rejected", 2'b00, 2'b00, 2'b00, 8'h00);
    applyStimulus(2'b01, 2'b00);
    tick(3);
    applyStimulus(2'b00, 2'b00);
    tick(1);
    t = cyc;
    applyStimulus(2'b01, 2'b00);
    expectEvent(t + 6, 2'b01, 2'b00, 2'b01, 8'h01);
    tick(5);
    checkOutput("glitch_restart_pending", 2'b00, 2'b00, 2'b00, 8'h00);
    tick(3);
    t = cyc;
    applyStimulus(2'b00, 2'b00);
    expectEvent(t + 6, 2'b00, 2'b01, 2'b00, 8'h01);
    tick(8);

    // Wrap on button 1
    applyReset();
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] kk;
      kk = k[3:0];
      pressRelease(2'b10, {kk, 4'h0});
    end
    checkOutput("wrap_to_zero", 2'b00, 2'b00, 2'b00, 8'h00);

    // Clear collision on button 0
    applyReset();
    pressRelease(2'b01, 8'h01);
    pressRelease(2'b01, 8'h02);
    pressRelease(2'b01, 8'h03);
    pressRelease(2'b01, 8'h04);
    pressRelease(2'b01, 8'h05);
    checkOutput("count_is_5", 2'b00, 2'b00, 2'b00, 8'h05);
    t = cyc;
    applyStimulus(2'b01, 2'b00);
    expectEvent(t + 6, 2'b01, 2'b00, 2'b01, 8'h01);
    tick(5);
    applyStimulus(2'b01, 2'b01);
    tick(1);
    applyStimulus(2'b01, 2'b00);
    tick(2);
    checkOutput("clear_with_press", 2'b01, 2'b00, 2'b00, 8'h01);
    applyStimulus(2'b01, 2'b01);
    tick(1);
    applyStimulus(2'b01, 2'b00);
    checkOutput("clear_alone", 2'b01, 2'b00, 2'b00, 8'h00);
    t = cyc;
    applyStimulus(2'b00, 2'b00);
    expectEvent(t + 6, 2'b00, 2'b01, 2'b00, 8'h00);
    tick(8);

    // Reset mid-debounce with raw held high
    applyReset();
    applyStimulus(2'b01, 2'b00);
    tick(3);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_reset_1", 2'b00, 2'b00, 2'b00, 8'h00);
    tick(1);
    checkOutput("mid_reset_2", 2'b00, 2'b00, 2'b00, 8'h00);
    reset = 1'b0;
    t = cyc;
    expectEvent(t + 6, 2'b01, 2'b00, 2'b01, 8'h01);
    tick(8);
    t = cyc;
    applyStimulus(2'b00, 2'b00);
    expectEvent(t + 6, 2'b00, 2'b01, 2'b00, 8'h01);
    tick(8);

    // Simultaneous channels
    applyReset();
    pressRelease(2'b11, 8'h11);
    checkOutput("simultaneous_final", 2'b00, 2'b00, 2'b00, 8'h11);

    tick(4);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      $display("[TB] FAIL missing_event got nothing want cyc=%0d press=%b rel=%b", e.at, e.press, e.rel);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
